// File: rtl/mssd_pkg.sv
// mssd_pkg: shared types and default constants for the parametrised serial-stream demux.
//   state_t  : frame decoder states
//   DEF_*    : default parameter values used by mssd_param
//   max_int  : helper to size the shared field counter
package mssd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    PAR
  } state_t;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_PARITY_EN = 1;
  localparam int DEF_EVEN_PAR  = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mssd_bit_counter.sv
// mssd_bit_counter: loadable down-counter shared by the ADDR, LEN and DATA fields.
//   gclk     : rising-edge clock
//   grst_n   : asynchronous active-low reset
//   load     : load load_val (has priority over en)
//   en       : decrement by one
//   load_val : value to load
//   zero     : count is currently zero (last bit of the current field)
module mssd_bit_counter #(
  parameter int W = 4
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mssd_param.sv
// mssd_param: parametrised multi-channel serial-stream demultiplexer.
// Frame (MSB first, one bit per cycle, no gaps):
//   start(0) | addr[ADDR_W] | len[LEN_W] | data[len] | parity (if PARITY_EN)
// Ports:
//   Clk        : rising-edge clock, serIn sampled every edge
//   reset      : asynchronous active-low reset
//   serIn      : serial line, idles high
//   p          : channel data, only p[d] may be 1 and only while out_valid
//   d          : index of channel currently served (held otherwise)
//   out_valid  : p[d] carries a payload bit this cycle
//   frame_done : 1-cycle pulse, frame completed cleanly
//   error      : 1-cycle pulse, frame rejected (bad address or parity)
module mssd_param
  import mssd_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int PARITY_EN = DEF_PARITY_EN,
  parameter int EVEN_PAR  = DEF_EVEN_PAR,
  localparam int ADDR_W   = $clog2(NUM_CH)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              serIn,
  output logic [NUM_CH-1:0] p,
  output logic [ADDR_W-1:0] d,
  output logic              out_valid,
  output logic              frame_done,
  output logic              error
);

  localparam int   CNT_W      = max_int(ADDR_W, LEN_W);
  localparam logic PAR_ON     = (PARITY_EN != 0);
  // accumulated XOR over addr/len/data/parity that a clean frame must hit
  localparam logic PAR_TARGET = (EVEN_PAR == 0);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_sr, addr_nxt;
  logic [LEN_W-1:0]  len_sr, len_nxt;
  logic              par_acc, par_nxt;
  logic              bad_addr;

  logic              cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;

  logic              beat;     // a payload bit is being sampled this cycle
  logic              eof;      // last bit of the frame is being sampled
  logic              fail;
  logic [NUM_CH-1:0] p_nxt;

  mssd_bit_counter #(.W(CNT_W)) u_cnt (
    .gclk     (Clk),
    .grst_n   (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign addr_nxt = ADDR_W'({addr_sr, serIn});
  assign len_nxt  = LEN_W'({len_sr, serIn});
  assign par_nxt  = par_acc ^ serIn;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // The counter is loaded with (field length - 1) so that zero marks the
  // last bit of each field; DATA is only entered with len != 0.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = '0;
    beat      = 1'b0;
    eof       = 1'b0;
    case (state)
      IDLE: begin
        if (!serIn) begin
          state_nxt = ADDR;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(ADDR_W - 1);
        end
      end
      ADDR: begin
        if (cnt_zero) begin
          state_nxt = LEN;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(LEN_W - 1);
        end else begin
          cnt_en = 1'b1;
        end
      end
      LEN: begin
        if (cnt_zero) begin
          if (len_nxt != '0) begin
            state_nxt = DATA;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(len_nxt - LEN_W'(1));
          end else if (PAR_ON) begin
            state_nxt = PAR;
          end else begin
            state_nxt = IDLE;
            eof       = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      DATA: begin
        beat = 1'b1;
        if (cnt_zero) begin
          if (PAR_ON) begin
            state_nxt = PAR;
          end else begin
            state_nxt = IDLE;
            eof       = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      PAR: begin
        state_nxt = IDLE;
        eof       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Without parity, par_nxt is ignored so only the address can reject.
  assign fail = bad_addr | (PAR_ON & (par_nxt != PAR_TARGET));

  always_comb begin
    p_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      p_nxt[i] = beat & ~bad_addr & serIn & (int'(addr_sr) == i);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      addr_sr    <= '0;
      len_sr     <= '0;
      par_acc    <= 1'b0;
      bad_addr   <= 1'b0;
      p          <= '0;
      d          <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (state == IDLE) begin
        // start bit itself is excluded from the parity
        par_acc <= 1'b0;
        if (!serIn) bad_addr <= 1'b0;
      end else begin
        par_acc <= par_nxt;
      end

      if (state == ADDR) begin
        addr_sr <= addr_nxt;
        if (cnt_zero) bad_addr <= (int'(addr_nxt) >= NUM_CH);
      end
      if (state == LEN) len_sr <= len_nxt;

      p         <= p_nxt;
      out_valid <= beat & ~bad_addr;
      if (beat && !bad_addr) d <= addr_sr;

      frame_done <= eof & ~fail;
      error      <= eof & fail;
    end
  end

endmodule
